// File: rtl/trivium_pkg.sv
// Shared Trivium constants, FSM state type and the key/IV state loader.
package trivium_pkg;

  localparam int TRIV_STATE_W = 288;
  localparam int TRIV_KEY_W   = 80;
  localparam int TRIV_IV_W    = 80;
  localparam int TRIV_WARMUP  = 1152;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    FILL,
    RUN
  } triv_state_e;

  // Bit i of the returned vector holds s(i+1).
  function automatic logic [TRIV_STATE_W-1:0] triv_load(
    input logic [TRIV_KEY_W-1:0] key,
    input logic [TRIV_IV_W-1:0]  iv
  );
    logic [TRIV_STATE_W-1:0] s;
    s          = '0;
    s[79:0]    = key;
    s[172:93]  = iv;
    s[287:285] = 3'b111;
    return s;
  endfunction

endpackage

// File: rtl/trivium_stream_core_if.sv
// Valid/ready stream bundle: s_* carries input words in, m_* carries results out.
interface trivium_stream_core_if #(
  parameter int DATA_W = 8
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [DATA_W-1:0] m_data;

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data
  );

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data
  );
endinterface

// File: rtl/trivium_round_unroll.sv
// Combinational N-round Trivium step; z[j] is the keystream bit of round j.
module trivium_round_unroll
  import trivium_pkg::*;
#(
  parameter int N = 1
) (
  input  logic [TRIV_STATE_W-1:0] state,
  output logic [TRIV_STATE_W-1:0] state_next,
  output logic [N-1:0]            z
);

  always_comb begin
    logic [TRIV_STATE_W-1:0] s;
    logic t1, t2, t3;
    s = state;
    z = '0;
    for (int j = 0; j < N; j++) begin
      t1   = s[65] ^ s[92];
      t2   = s[161] ^ s[176];
      t3   = s[242] ^ s[287];
      z[j] = t1 ^ t2 ^ t3;
      t1   = t1 ^ (s[90] & s[91]) ^ s[170];
      t2   = t2 ^ (s[174] & s[175]) ^ s[263];
      t3   = t3 ^ (s[285] & s[286]) ^ s[68];
      // One left shift moves all three registers; their heads are then overwritten.
      s      = {s[286:0], t3};
      s[93]  = t1;
      s[177] = t2;
    end
    state_next = s;
  end

endmodule

// File: rtl/trivium_stream_core.sv
// Trivium keystream engine with valid/ready streaming XOR datapath.
// Optional TRIVIUM_WORD_CNT_EN adds a saturating accepted-word counter port.
module trivium_stream_core
  import trivium_pkg::*;
#(
  parameter int DATA_W        = 8,
  parameter int BITS_PER_CLK  = 1,
  parameter int WARMUP_ROUNDS = TRIV_WARMUP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init,
  input  logic [TRIV_KEY_W-1:0] key,
  input  logic [TRIV_IV_W-1:0]  iv,
  output logic                  busy,
`ifdef TRIVIUM_WORD_CNT_EN
  output logic [31:0]           word_cnt,
`endif
  trivium_stream_core_if.slave  bus
);

  localparam int S      = DATA_W / BITS_PER_CLK;
  localparam int W      = WARMUP_ROUNDS / BITS_PER_CLK;
  localparam int WCNT_W = $clog2(W + 1);
  localparam int FCNT_W = $clog2(S + 1);

  triv_state_e              state, state_nxt;
  logic [TRIV_STATE_W-1:0]  cs, cs_nxt, cs_step;
  logic [BITS_PER_CLK-1:0]  z;
  logic [DATA_W-1:0]        ks, ks_nxt, m_data_nxt;
  logic                     ks_full, ks_full_nxt, m_valid_nxt;
  logic [WCNT_W-1:0]        wcnt, wcnt_nxt;
  logic [FCNT_W-1:0]        fcnt, fcnt_nxt;
  logic                     accept;

  function automatic logic [DATA_W-1:0] ks_insert(
    input logic [DATA_W-1:0]       w,
    input logic [FCNT_W-1:0]       slot,
    input logic [BITS_PER_CLK-1:0] bits
  );
    for (int k = 0; k < S; k++)
      if (slot == FCNT_W'(k)) w[k*BITS_PER_CLK +: BITS_PER_CLK] = bits;
    return w;
  endfunction

  assign bus.s_ready = ks_full && (!bus.m_valid || bus.m_ready) && !init;
  assign accept      = bus.s_valid && bus.s_ready;
  assign busy        = (state == WARMUP);

  trivium_round_unroll #(.N(BITS_PER_CLK)) u_round (
    .state      (cs),
    .state_next (cs_step),
    .z          (z)
  );

  always_comb begin
    state_nxt   = state;
    cs_nxt      = cs;
    ks_nxt      = ks;
    ks_full_nxt = ks_full;
    wcnt_nxt    = wcnt;
    fcnt_nxt    = fcnt;
    m_valid_nxt = bus.m_valid;
    m_data_nxt  = bus.m_data;
    if (init) begin
      cs_nxt      = triv_load(key, iv);
      state_nxt   = WARMUP;
      ks_full_nxt = 1'b0;
      m_valid_nxt = 1'b0;
      wcnt_nxt    = '0;
      fcnt_nxt    = '0;
    end else begin
      if (accept) begin
        m_data_nxt  = bus.s_data ^ ks;
        m_valid_nxt = 1'b1;
      end else if (bus.m_ready) begin
        m_valid_nxt = 1'b0;
      end
      unique case (state)
        WARMUP: begin
          cs_nxt = cs_step;
          if (wcnt == WCNT_W'(W - 1)) begin
            state_nxt = FILL;
            wcnt_nxt  = '0;
          end else begin
            wcnt_nxt = wcnt + WCNT_W'(1);
          end
        end
        FILL: begin
          cs_nxt = cs_step;
          ks_nxt = ks_insert(ks, fcnt, z);
          if (fcnt == FCNT_W'(S - 1)) begin
            ks_full_nxt = 1'b1;
            state_nxt   = RUN;
            fcnt_nxt    = '0;
          end else begin
            fcnt_nxt = fcnt + FCNT_W'(1);
          end
        end
        RUN: begin
          // The accepting clock already produces the first slot of the next word.
          if (accept) begin
            cs_nxt = cs_step;
            ks_nxt = ks_insert(ks, '0, z);
            if (S != 1) begin
              ks_full_nxt = 1'b0;
              state_nxt   = FILL;
              fcnt_nxt    = FCNT_W'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cs          <= '0;
      ks          <= '0;
      ks_full     <= 1'b0;
      wcnt        <= '0;
      fcnt        <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
    end else begin
      state       <= state_nxt;
      cs          <= cs_nxt;
      ks          <= ks_nxt;
      ks_full     <= ks_full_nxt;
      wcnt        <= wcnt_nxt;
      fcnt        <= fcnt_nxt;
      bus.m_valid <= m_valid_nxt;
      bus.m_data  <= m_data_nxt;
    end
  end

`ifdef TRIVIUM_WORD_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                          word_cnt <= '0;
    else if (init)                       word_cnt <= '0;
    else if (accept && word_cnt != '1)   word_cnt <= word_cnt + 32'd1;
  end
`endif

endmodule

// File: tb/tb_trivium_stream_core.sv
// Scoreboard bench: bit-level Trivium reference model, three parallelism configs.
module tb_trivium_stream_core;

  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err = 0;

  // 8-bit word, 1 bit per clock
  logic        init_a = 1'b0;
  logic [79:0] key_a = '0, iv_a = '0;
  logic        busy_a;
  logic [31:0] wc_a;
  trivium_stream_core_if #(.DATA_W(8)) bus_a ();
  trivium_stream_core #(.DATA_W(8), .BITS_PER_CLK(1), .WARMUP_ROUNDS(1152)) dut_a (
    .clk(clk), .rst_n(rst_n), .init(init_a), .key(key_a), .iv(iv_a), .busy(busy_a),
`ifdef TRIVIUM_WORD_CNT_EN
    .word_cnt(wc_a),
`endif
    .bus(bus_a)
  );

  // 64-bit word, 8 and 64 bits per clock, sharing key/iv/init
  logic        init_bc = 1'b0;
  logic [79:0] key_bc = '0, iv_bc = '0;
  logic        busy_b, busy_c;
  logic [31:0] wc_b, wc_c;
  trivium_stream_core_if #(.DATA_W(64)) bus_b ();
  trivium_stream_core_if #(.DATA_W(64)) bus_c ();
  trivium_stream_core #(.DATA_W(64), .BITS_PER_CLK(8), .WARMUP_ROUNDS(1152)) dut_b (
    .clk(clk), .rst_n(rst_n), .init(init_bc), .key(key_bc), .iv(iv_bc), .busy(busy_b),
`ifdef TRIVIUM_WORD_CNT_EN
    .word_cnt(wc_b),
`endif
    .bus(bus_b)
  );
  trivium_stream_core #(.DATA_W(64), .BITS_PER_CLK(64), .WARMUP_ROUNDS(1152)) dut_c (
    .clk(clk), .rst_n(rst_n), .init(init_bc), .key(key_bc), .iv(iv_bc), .busy(busy_c),
`ifdef TRIVIUM_WORD_CNT_EN
    .word_cnt(wc_c),
`endif
    .bus(bus_c)
  );

  bitq_t       ks_a, ks_b, ks_c;
  logic [63:0] exp_a[$], exp_b[$], exp_c[$];
  logic [7:0]  cap_a[$];

  function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endfunction

  // Reference keystream: s[1..288] as in the cipher definition, warm-up discarded.
  function automatic bitq_t gen_ks(input logic [79:0] k, input logic [79:0] v, input int nbits);
    bit    s[1:288];
    bitq_t q;
    bit    t1, t2, t3, zz;
    for (int i = 1; i <= 288; i++) s[i] = 1'b0;
    for (int i = 1; i <= 80; i++) begin
      s[i]      = k[i-1];
      s[93 + i] = v[i-1];
    end
    s[286] = 1'b1; s[287] = 1'b1; s[288] = 1'b1;
    for (int r = 0; r < 1152 + nbits; r++) begin
      t1 = s[66] ^ s[93];
      t2 = s[162] ^ s[177];
      t3 = s[243] ^ s[288];
      zz = t1 ^ t2 ^ t3;
      t1 = t1 ^ (s[91] & s[92]) ^ s[171];
      t2 = t2 ^ (s[175] & s[176]) ^ s[264];
      t3 = t3 ^ (s[286] & s[287]) ^ s[69];
      for (int i = 288; i > 1; i--) s[i] = s[i-1];
      s[1] = t3; s[94] = t1; s[178] = t2;
      if (r >= 1152) q.push_back(zz);
    end
    return q;
  endfunction

  function automatic logic [63:0] pop_ks(ref bitq_t q, input int n);
    logic [63:0] w = '0;
    for (int i = 0; i < n; i++) w[i] = q.pop_front();
    return w;
  endfunction

  // Monitors: one transfer per cycle where m_valid && m_ready before the edge.
  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (rst_n && bus_a.m_valid && bus_a.m_ready) begin
      if (exp_a.size() == 0) chk("a_unexpected_word", {56'b0, bus_a.m_data}, 64'hx);
      else begin
        e = exp_a.pop_front();
        chk("a_word", {56'b0, bus_a.m_data}, e);
        cap_a.push_back(bus_a.m_data);
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (rst_n && bus_b.m_valid && bus_b.m_ready) begin
      if (exp_b.size() == 0) chk("b_unexpected_word", bus_b.m_data, 64'hx);
      else begin
        e = exp_b.pop_front();
        chk("b_word", bus_b.m_data, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [63:0] e;
    #2;
    if (rst_n && bus_c.m_valid && bus_c.m_ready) begin
      if (exp_c.size() == 0) chk("c_unexpected_word", bus_c.m_data, 64'hx);
      else begin
        e = exp_c.pop_front();
        chk("c_word", bus_c.m_data, e);
      end
    end
  end

  task automatic do_init_a(input logic [79:0] k, input logic [79:0] v);
    @(negedge clk);
    key_a  = k;
    iv_a   = v;
    init_a = 1'b1;
    ks_a   = gen_ks(k, v, 256);
    exp_a.delete();
    @(negedge clk);
    init_a = 1'b0;
  endtask

  task automatic send_a(input logic [7:0] d);
    bit          done = 1'b0;
    logic [63:0] w;
    for (int i = 0; i < 3000 && !done; i++) begin
      @(negedge clk);
      bus_a.s_valid = 1'b1;
      bus_a.s_data  = d;
      #1;
      if (bus_a.s_ready) begin
        w = pop_ks(ks_a, 8);
        exp_a.push_back({56'b0, d ^ w[7:0]});
        @(posedge clk);
        #1;
        bus_a.s_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) chk("a_send_timeout", 64'(done), 64'd1);
  endtask

  task automatic drain_a();
    for (int i = 0; i < 2000 && exp_a.size() != 0; i++) @(negedge clk);
    chk("a_drain", 64'(exp_a.size()), 64'd0);
  endtask

  // Call at the negedge after the init edge; counts cycles with busy high.
  task automatic measure_busy(input string name);
    int cnt = 0;
    for (int i = 0; i < 5000; i++) begin
      if (!busy_a) break;
      cnt++;
      @(negedge clk);
    end
    chk(name, 64'(cnt), 64'd1152);
  endtask

  task automatic run_a();
    logic [7:0]  pt[4] = '{8'hDE, 8'hAD, 8'hBE, 8'hEF};
    logic [7:0]  ct[4];
    logic [79:0] k, v;
    logic [63:0] e1;
    int          c;

    // Warm-up and fill timing from an all-zero key/IV
    do_init_a(80'h0, 80'h0);
    measure_busy("a_busy_cycles");
    c = 0;
    while (!bus_a.s_ready && c < 100) begin
      @(negedge clk);
      #1;
      c++;
    end
    chk("a_ready_after_busy", 64'(c), 64'd8);
    repeat (4) send_a(8'($urandom));
    drain_a();

    // Round trip
    k = 80'h0123456789ABCDEF0123;
    v = 80'h23;
    do_init_a(k, v);
    cap_a.delete();
    for (int i = 0; i < 4; i++) send_a(pt[i]);
    drain_a();
    for (int i = 0; i < 4; i++) ct[i] = cap_a[i];
    do_init_a(k, v);
    cap_a.delete();
    for (int i = 0; i < 4; i++) send_a(ct[i]);
    drain_a();
    for (int i = 0; i < 4; i++) chk("rt_plain", {56'b0, cap_a[i]}, {56'b0, pt[i]});

    // Backpressure: output held, input stalled, then the next keystream is used
    k = {16'($urandom), $urandom, $urandom};
    v = {16'($urandom), $urandom, $urandom};
    do_init_a(k, v);
    @(negedge clk);
    bus_a.m_ready = 1'b0;
    send_a(8'($urandom));
    e1 = exp_a[0];
    @(negedge clk);
    bus_a.s_valid = 1'b1;
    bus_a.s_data  = 8'($urandom);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      #1;
      chk("bp_hold", {54'b0, bus_a.s_ready, bus_a.m_valid, bus_a.m_data}, {54'b0, 1'b0, 1'b1, e1[7:0]});
    end
    bus_a.m_ready = 1'b1;
    bus_a.s_valid = 1'b0;
    send_a(8'($urandom));
    drain_a();

    // Re-init during warm-up
    do_init_a(k, v);
    repeat (499) @(negedge clk);
    chk("warmup_busy_500", 64'(busy_a), 64'd1);
    do_init_a(k, v);
    measure_busy("a_busy_after_restart");
    repeat (3) send_a(8'($urandom));
    drain_a();

    // Re-init during RUN with a pending output word
    @(negedge clk);
    bus_a.m_ready = 1'b0;
    send_a(8'($urandom));
    repeat (10) @(negedge clk);
    chk("run_pending_valid", 64'(bus_a.m_valid), 64'd1);
    k = {16'($urandom), $urandom, $urandom};
    key_a = k; iv_a = v; init_a = 1'b1;
    bus_a.s_valid = 1'b1;
    ks_a = gen_ks(k, v, 256);
    exp_a.delete();
    #1;
    chk("init_blocks_ready_run", 64'(bus_a.s_ready), 64'd0);
    @(negedge clk);
    init_a = 1'b0;
    bus_a.s_valid = 1'b0;
    bus_a.m_ready = 1'b1;
    chk("init_drops_valid", {62'b0, bus_a.m_valid, busy_a}, {62'b0, 1'b0, 1'b1});
    measure_busy("a_busy_after_run_init");
    repeat (3) send_a(8'($urandom));
    drain_a();

    // init on a would-be accept edge: the word is not consumed
    repeat (10) @(negedge clk);
    #1;
    chk("ready_before_init", 64'(bus_a.s_ready), 64'd1);
    @(negedge clk);
    v = {16'($urandom), $urandom, $urandom};
    key_a = k; iv_a = v; init_a = 1'b1;
    bus_a.s_valid = 1'b1;
    bus_a.s_data = 8'($urandom);
    ks_a = gen_ks(k, v, 256);
    #1;
    chk("init_blocks_ready_idle", 64'(bus_a.s_ready), 64'd0);
    @(negedge clk);
    init_a = 1'b0;
    bus_a.s_valid = 1'b0;
    chk("suppressed_no_output", 64'(bus_a.m_valid), 64'd0);
    measure_busy("a_busy_after_supp_init");
    repeat (2) send_a(8'($urandom));
    drain_a();

`ifdef TRIVIUM_WORD_CNT_EN
    do_init_a(k, v);
    repeat (5) send_a(8'($urandom));
    drain_a();
    chk("word_cnt_5", 64'(wc_a), 64'd5);
    do_init_a(k, v);
    chk("word_cnt_cleared", 64'(wc_a), 64'd0);
`endif
  endtask

  task automatic run_bc();
    logic [63:0] din[3];
    for (int i = 0; i < 3; i++) din[i] = {$urandom, $urandom};
    @(negedge clk);
    key_bc  = {16'($urandom), $urandom, $urandom};
    iv_bc   = {16'($urandom), $urandom, $urandom};
    init_bc = 1'b1;
    ks_b    = gen_ks(key_bc, iv_bc, 256);
    ks_c    = ks_b;
    @(negedge clk);
    init_bc = 1'b0;
    fork
      for (int w = 0; w < 3; w++) begin
        bit done = 1'b0;
        for (int i = 0; i < 3000 && !done; i++) begin
          @(negedge clk);
          bus_b.s_valid = 1'b1;
          bus_b.s_data  = din[w];
          #1;
          if (bus_b.s_ready) begin
            exp_b.push_back(din[w] ^ pop_ks(ks_b, 64));
            @(posedge clk);
            #1;
            bus_b.s_valid = 1'b0;
            done = 1'b1;
          end
        end
        if (!done) chk("b_send_timeout", 64'(done), 64'd1);
      end
      for (int w = 0; w < 3; w++) begin
        bit done = 1'b0;
        int tries = 0;
        for (int i = 0; i < 3000 && !done; i++) begin
          @(negedge clk);
          bus_c.s_valid = 1'b1;
          bus_c.s_data  = din[w];
          tries++;
          #1;
          if (bus_c.s_ready) begin
            exp_c.push_back(din[w] ^ pop_ks(ks_c, 64));
            @(posedge clk);
            #1;
            bus_c.s_valid = 1'b0;
            done = 1'b1;
          end
        end
        if (w > 0) chk("c_back_to_back", 64'(tries), 64'd1);
        if (!done) chk("c_send_timeout", 64'(done), 64'd1);
      end
    join
    for (int i = 0; i < 2000 && (exp_b.size() != 0 || exp_c.size() != 0); i++) @(negedge clk);
    chk("bc_drain", 64'(exp_b.size() + exp_c.size()), 64'd0);
  endtask

  initial begin
    bus_a.s_valid = 1'b0; bus_a.s_data = '0; bus_a.m_ready = 1'b1;
    bus_b.s_valid = 1'b0; bus_b.s_data = '0; bus_b.m_ready = 1'b1;
    bus_c.s_valid = 1'b0; bus_c.s_data = '0; bus_c.m_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_s_ready", 64'(bus_a.s_ready), 64'd0);
    chk("rst_m_valid", 64'(bus_a.m_valid), 64'd0);
    chk("rst_m_data", {56'b0, bus_a.m_data}, 64'd0);
    chk("rst_bc_valid", {62'b0, bus_b.m_valid, bus_c.m_valid}, 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_no_busy", 64'(busy_a), 64'd0);

    fork
      run_a();
      run_bc();
    join

    // Asynchronous reset with an output word pending
    do_init_a(80'h5, 80'h9);
    measure_busy("a_busy_before_reset");
    @(negedge clk);
    bus_a.m_ready = 1'b0;
    send_a(8'($urandom));
    @(negedge clk);
    chk("pending_before_reset", 64'(bus_a.m_valid), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("reset_mid_stream", {54'b0, bus_a.m_valid, bus_a.s_ready, bus_a.m_data},
        {54'b0, 1'b0, 1'b0, 8'h00});
    exp_a.delete();
    @(negedge clk);
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
